// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with three combinational read
// ports, an ALU write port (D), a late load writeback port (L), optional
// same-cycle write-to-read bypass and a per-register load-pending
// scoreboard. Register 0 always reads as zero.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] nA,
    input  logic [ADDR_W-1:0] nB,
    input  logic [ADDR_W-1:0] nC,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic              BusyA,
    output logic              BusyB,
    output logic              BusyC,
    input  logic [ADDR_W-1:0] nD,
    input  logic [DATA_W-1:0] D,
    input  logic              RegWE,
    input  logic [ADDR_W-1:0] nL,
    input  logic [DATA_W-1:0] L,
    input  logic              LdWE,
    input  logic              PendSet,
    input  logic [ADDR_W-1:0] nP,
    output logic [ADDR_W:0]   PendCount,
    output logic              Collision
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_next;
    logic [ADDR_W:0]     pend_count_next;
    logic                d_write;
    logic                l_write;
    logic                collide;

    // Qualified write strobes; the load port yields to the ALU port on a clash
    always_comb begin
        d_write = RegWE && (nD != '0);
        collide = d_write && LdWE && (nL == nD);
        l_write = LdWE && (nL != '0) && !collide;
    end

    // Read mux: zero register, then optional bypass (D before L), then storage
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = regs[idx];
        if (idx == '0)
            v = '0;
        else if ((BYPASS != 0) && d_write && (nD == idx))
            v = D;
        else if ((BYPASS != 0) && LdWE && (nL == idx))
            v = L;
        return v;
    endfunction

    // Combinational read data and busy flags from current state
    always_comb begin
        A     = read_port(nA);
        B     = read_port(nB);
        C     = read_port(nC);
        BusyA = pending[nA];
        BusyB = pending[nB];
        BusyC = pending[nC];
    end

    // Next scoreboard state: load return clears, new load issue sets and wins
    always_comb begin
        pend_next = pending;
        if (LdWE)
            pend_next[nL] = 1'b0;
        if (PendSet && (nP != '0))
            pend_next[nP] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Population count of the next scoreboard so PendCount tracks it exactly
    always_comb begin
        pend_count_next = '0;
        for (int i = 0; i < NUM_REGS; i++)
            pend_count_next = pend_count_next + (ADDR_W + 1)'(pend_next[i]);
    end

    // Register storage; reset wipes everything including in-flight writes
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (d_write && (nD == ADDR_W'(i)))
                    regs[i] <= D;
                else if (l_write && (nL == ADDR_W'(i)))
                    regs[i] <= L;
            end
        end
    end

    // Scoreboard, pending count and sticky collision flag
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending   <= '0;
            PendCount <= '0;
            Collision <= 1'b0;
        end else begin
            pending   <= pend_next;
            PendCount <= pend_count_next;
            if (collide)
                Collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb. Two instances
// share all inputs: one with bypass, one without, so both read timings
// are checked against the same stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        Reset_n;
    logic [3:0]  nA, nB, nC, nD, nL, nP;
    logic [15:0] D, L;
    logic        RegWE, LdWE, PendSet;

    logic [15:0] A, B, C, A0, B0, C0;
    logic        BusyA, BusyB, BusyC, BusyA0, BusyB0, BusyC0;
    logic [4:0]  PendCount, PendCount0;
    logic        Collision, Collision0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t expq[$];
    int   checks;
    int   fails;

    localparam int S_A = 0, S_B = 1, S_C = 2, S_BUSYA = 3, S_BUSYB = 4,
                   S_BUSYC = 5, S_CNT = 6, S_COL = 7, S_A0 = 8;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .nA(nA), .nB(nB), .nC(nC), .A(A), .B(B), .C(C),
        .BusyA(BusyA), .BusyB(BusyB), .BusyC(BusyC),
        .nD(nD), .D(D), .RegWE(RegWE), .nL(nL), .L(L), .LdWE(LdWE),
        .PendSet(PendSet), .nP(nP), .PendCount(PendCount), .Collision(Collision)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0)) dut0 (
        .clk(clk), .Reset_n(Reset_n),
        .nA(nA), .nB(nB), .nC(nC), .A(A0), .B(B0), .C(C0),
        .BusyA(BusyA0), .BusyB(BusyB0), .BusyC(BusyC0),
        .nD(nD), .D(D), .RegWE(RegWE), .nL(nL), .L(L), .LdWE(LdWE),
        .PendSet(PendSet), .nP(nP), .PendCount(PendCount0), .Collision(Collision0)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_A:     return {16'h0, A};
            S_B:     return {16'h0, B};
            S_C:     return {16'h0, C};
            S_BUSYA: return {31'h0, BusyA};
            S_BUSYB: return {31'h0, BusyB};
            S_BUSYC: return {31'h0, BusyC};
            S_CNT:   return {27'h0, PendCount};
            S_COL:   return {31'h0, Collision};
            S_A0:    return {16'h0, A0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        expq.push_back(e);
    endtask

    // Start a new cycle at the falling edge with all write controls idle
    task automatic applyStimulus();
        @(negedge clk);
        RegWE   = 1'b0;
        LdWE    = 1'b0;
        PendSet = 1'b0;
        nD = '0; nL = '0; nP = '0;
        D  = '0; L  = '0;
    endtask

    // Let combinational outputs settle, then drain the scoreboard queue
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (expq.size() > 0) begin
            e   = expq.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                fails++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        Reset_n = 1'b0;
        RegWE = 0; LdWE = 0; PendSet = 0;
        nA = 0; nB = 0; nC = 0; nD = 0; nL = 0; nP = 0; D = 0; L = 0;

        // Reset state
        applyStimulus();
        nA = 4'd1; nB = 4'd2; nC = 4'd15;
        expect_val("rst_busyA", S_BUSYA, 0);
        expect_val("rst_busyB", S_BUSYB, 0);
        expect_val("rst_busyC", S_BUSYC, 0);
        expect_val("rst_count", S_CNT, 0);
        expect_val("rst_coll", S_COL, 0);
        checkOutput();

        applyStimulus();
        Reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            nA = 4'(i); nB = 4'(i); nC = 4'(i);
            expect_val($sformatf("rst_A%0d", i), S_A, 0);
            expect_val($sformatf("rst_B%0d", i), S_B, 0);
            expect_val($sformatf("rst_C%0d", i), S_C, 0);
            checkOutput();
        end

        // ALU write with same-cycle bypass versus no-bypass
        applyStimulus();
        RegWE = 1; nD = 4'd5; D = 16'h1234; nA = 4'd5;
        expect_val("byp_A", S_A, 16'h1234);
        expect_val("nobyp_A", S_A0, 16'h0000);
        checkOutput();
        applyStimulus();
        nA = 4'd5;
        expect_val("wr5_A", S_A, 16'h1234);
        expect_val("wr5_A0", S_A0, 16'h1234);
        checkOutput();

        // Register 0 ignores writes and pending marks
        applyStimulus();
        RegWE = 1; nD = 4'd0; D = 16'hFFFF; nB = 4'd0;
        expect_val("r0_byp_B", S_B, 0);
        checkOutput();
        applyStimulus();
        PendSet = 1; nP = 4'd0; nB = 4'd0; nA = 4'd0;
        expect_val("r0_B", S_B, 0);
        checkOutput();
        applyStimulus();
        nA = 4'd0;
        expect_val("r0_busyA", S_BUSYA, 0);
        expect_val("r0_count", S_CNT, 0);
        checkOutput();

        // Load issue, busy visible next cycle, load return clears it
        applyStimulus();
        PendSet = 1; nP = 4'd3; nC = 4'd3;
        expect_val("p3_busy_same", S_BUSYC, 0);
        checkOutput();
        applyStimulus();
        LdWE = 1; nL = 4'd3; L = 16'hBEEF; nC = 4'd3;
        expect_val("p3_busy", S_BUSYC, 1);
        expect_val("p3_count", S_CNT, 1);
        expect_val("p3_ld_byp_C", S_C, 16'hBEEF);
        checkOutput();
        applyStimulus();
        nC = 4'd3;
        expect_val("p3_busy_clr", S_BUSYC, 0);
        expect_val("p3_C", S_C, 16'hBEEF);
        expect_val("p3_count_clr", S_CNT, 0);
        checkOutput();

        // Set and clear of the same register: set wins
        applyStimulus();
        PendSet = 1; nP = 4'd7;
        checkOutput();
        applyStimulus();
        PendSet = 1; nP = 4'd7; LdWE = 1; nL = 4'd7; L = 16'h7777; nA = 4'd7;
        expect_val("p7_count", S_CNT, 1);
        expect_val("p7_byp_A", S_A, 16'h7777);
        expect_val("p7_busy_same", S_BUSYA, 1);
        checkOutput();
        applyStimulus();
        PendSet = 1; nP = 4'd7; nA = 4'd7;
        expect_val("p7_busy_kept", S_BUSYA, 1);
        expect_val("p7_count_kept", S_CNT, 1);
        expect_val("p7_A", S_A, 16'h7777);
        checkOutput();

        // Load to a non-pending register, plus a new load issue on 9
        applyStimulus();
        LdWE = 1; nL = 4'd8; L = 16'h8888; PendSet = 1; nP = 4'd9;
        expect_val("p7_reset_count", S_CNT, 1);
        checkOutput();
        applyStimulus();
        nB = 4'd8; nA = 4'd9;
        expect_val("ld8_B", S_B, 16'h8888);
        expect_val("ld8_busyB", S_BUSYB, 0);
        expect_val("p9_busyA", S_BUSYA, 1);
        expect_val("p9_count", S_CNT, 2);
        checkOutput();

        // Independent ALU and load writes in one cycle
        applyStimulus();
        RegWE = 1; nD = 4'd10; D = 16'hAAAA; LdWE = 1; nL = 4'd11; L = 16'hBBBB; nB = 4'd11;
        expect_val("dual_byp_B", S_B, 16'hBBBB);
        checkOutput();
        applyStimulus();
        nA = 4'd10; nB = 4'd11;
        expect_val("dual_A", S_A, 16'hAAAA);
        expect_val("dual_B", S_B, 16'hBBBB);
        checkOutput();

        // Collision on register 9: D wins, pending cleared, flag sticky
        applyStimulus();
        RegWE = 1; nD = 4'd9; D = 16'h0001; LdWE = 1; nL = 4'd9; L = 16'h0002; nA = 4'd9;
        expect_val("col_byp_A", S_A, 16'h0001);
        expect_val("col_flag_before", S_COL, 0);
        checkOutput();
        applyStimulus();
        nA = 4'd9;
        expect_val("col_A", S_A, 16'h0001);
        expect_val("col_A0", S_A0, 16'h0001);
        expect_val("col_flag", S_COL, 1);
        expect_val("col_busyA", S_BUSYA, 0);
        expect_val("col_count", S_CNT, 1);
        checkOutput();
        applyStimulus();
        expect_val("col_sticky", S_COL, 1);
        checkOutput();

        // Asynchronous reset mid-run with a write in flight
        applyStimulus();
        RegWE = 1; nD = 4'd12; D = 16'hCCCC; nA = 4'd5; nB = 4'd7; nC = 4'd7;
        #1;
        Reset_n = 1'b0;
        expect_val("mrst_A", S_A, 0);
        expect_val("mrst_busyC", S_BUSYC, 0);
        expect_val("mrst_count", S_CNT, 0);
        expect_val("mrst_coll", S_COL, 0);
        checkOutput();

        // First write accepted on the first edge after release
        applyStimulus();
        Reset_n = 1'b1;
        RegWE = 1; nD = 4'd6; D = 16'h6666;
        checkOutput();
        applyStimulus();
        nA = 4'd6; nB = 4'd12;
        expect_val("rel_A", S_A, 16'h6666);
        expect_val("rel_A0", S_A0, 16'h6666);
        expect_val("rel_B12", S_B, 0);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
